// File: rtl/afc_pkg.sv
// Shared types and helpers for the AFC successive-approximation calibrator.
// Holds the SAR state encoding, the TMR majority vote and the reset midpoint code.
package afc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DECIDE,
        ST_FINISH
    } afc_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic int unsigned MIDPOINT(input int unsigned code_w);
        return 32'd1 << (code_w - 1);
    endfunction

endpackage

// File: rtl/afc_window_counter.sv
// Saturating feedback-strobe counter for one measurement window.
// Clear wins over enable; once all-ones the count holds until cleared.
module afc_window_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk40M,
    input  logic             RST,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             fb_edge_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: count_d is given its hold value first so no path through this block leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && fb_edge_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk40M) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/afc_sar_calibrator.sv
// SAR calibration of the VCO capacitor code: settle, count feedback strobes over a
// window, keep or clear one bit per pass. Also votes the TMR controls and muxes outputs.
module afc_sar_calibrator
    import afc_pkg::*;
#(
    parameter int CODE_W = 6,
    parameter int CNT_W  = 12,
    parameter int WINDOW = 256,
    parameter int SETTLE = 16,
    parameter int TARGET = 128
) (
    input  logic              clk40M,
    input  logic              RST,
    input  logic              startA,
    input  logic              startB,
    input  logic              startC,
    input  logic              modeA,
    input  logic              modeB,
    input  logic              modeC,
    input  logic              overrideCtrlA,
    input  logic              overrideCtrlB,
    input  logic              overrideCtrlC,
    input  logic [CODE_W-1:0] overrideVal,
    input  logic              enPLL_cfg,
    input  logic              overrideVc_cfg,
    input  logic              fbEdge,
    output logic [CODE_W-1:0] capCode,
    output logic [CODE_W-1:0] calCode,
    output logic              busy,
    output logic              done,
    output logic              calErr,
    output logic [CNT_W-1:0]  lastCount,
    output logic              pllEnable,
    output logic              overrideVc
);

    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_W   = $clog2(CODE_W);
    localparam logic [CODE_W-1:0] MID_CODE   = CODE_W'(MIDPOINT(CODE_W));
    localparam logic [CNT_W-1:0]  TARGET_CNT = CNT_W'(TARGET);

    logic mode_v_q, start_v_q, ovr_v_q, start_prev_q, mode_prev_q;

    afc_state_e        state_q;
    logic [TMR_W-1:0]  timer_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CODE_W-1:0] trial_q, trial_d;
    logic [CODE_W-1:0] cal_code_q;
    logic              busy_q, done_q, cal_err_q;
    logic [CNT_W-1:0]  last_count_q;
    logic [CNT_W-1:0]  win_count;

    logic              start_edge, mode_rise, keep_bit;
    logic [CODE_W-1:0] bit_mask;

    always_ff @(posedge clk40M) begin
        if (RST) begin
            mode_v_q     <= 1'b0;
            start_v_q    <= 1'b0;
            ovr_v_q      <= 1'b0;
            start_prev_q <= 1'b0;
            mode_prev_q  <= 1'b0;
        end else begin
            mode_v_q     <= maj3(modeA, modeB, modeC);
            start_v_q    <= maj3(startA, startB, startC);
            ovr_v_q      <= maj3(overrideCtrlA, overrideCtrlB, overrideCtrlC);
            start_prev_q <= start_v_q;
            mode_prev_q  <= mode_v_q;
        end
    end

    assign start_edge = start_v_q & ~start_prev_q;
    assign mode_rise  = mode_v_q & ~mode_prev_q;

    afc_window_counter #(.CNT_W(CNT_W)) u_window_counter (
        .clk40M    (clk40M),
        .RST       (RST),
        .clear_i   (state_q == ST_SETTLE),
        .enable_i  (state_q == ST_MEASURE),
        .fb_edge_i (fbEdge),
        .count_o   (win_count)
    );

    // A count above target means the VCO is still fast, so the trial bit stays set.
    assign bit_mask = CODE_W'(1) << idx_q;
    assign keep_bit = win_count > TARGET_CNT;

    always_comb begin
        trial_d = keep_bit ? trial_q : (trial_q & ~bit_mask);
        if (idx_q != '0) begin
            trial_d = trial_d | (bit_mask >> 1);
        end
    end

    // NOTE: every register here uses <= so all branches read the pre-edge values consistently.
    always_ff @(posedge clk40M) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            trial_q      <= MID_CODE;
            cal_code_q   <= MID_CODE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cal_err_q    <= 1'b0;
            last_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && mode_rise) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_edge && !mode_v_q) begin
                            busy_q  <= 1'b1;
                            idx_q   <= IDX_W'(CODE_W - 1);
                            trial_q <= MID_CODE;
                            timer_q <= '0;
                            state_q <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer_q == TMR_W'(SETTLE - 1)) begin
                            timer_q <= '0;
                            state_q <= ST_MEASURE;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (timer_q == TMR_W'(WINDOW - 1)) begin
                            timer_q <= '0;
                            state_q <= ST_DECIDE;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                    ST_DECIDE: begin
                        last_count_q <= win_count;
                        trial_q      <= trial_d;
                        if (idx_q != '0) begin
                            idx_q   <= idx_q - IDX_W'(1);
                            state_q <= ST_SETTLE;
                        end else begin
                            state_q <= ST_FINISH;
                        end
                    end
                    ST_FINISH: begin
                        cal_code_q <= trial_q;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cal_err_q  <= (trial_q == '0) || (trial_q == '1);
                        state_q    <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign capCode    = (mode_v_q && ovr_v_q) ? overrideVal : (busy_q ? trial_q : cal_code_q);
    assign calCode    = cal_code_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign calErr     = cal_err_q;
    assign lastCount  = last_count_q;
    assign pllEnable  = mode_v_q ? enPLL_cfg : ~busy_q;
    assign overrideVc = mode_v_q ? overrideVc_cfg : busy_q;

endmodule

// File: doc/afc_sar_calibrator.md
Name: afc_sar_calibrator

Overview:
- Parametrised successor to the fixed 6-bit AFC plus bit-protector path feeding the PLL VCO capacitor bank.
- Runs a successive-approximation calibration of a CODE_W-bit capacitor code. It counts feedback-divider strobes over a programmable reference window and compares the count against TARGET.
- Majority-votes triplicated start, mode and override controls. Drives the PLL enable and Vc-override muxing, and holds the protected final code.
- Sits between the I2C config registers and the PLL core, one instance per PLL.

Parameters:
- CODE_W, 6: capacitor code width (>=2).
- CNT_W, 12: feedback strobe counter width; counter saturates.
- WINDOW, 256: measurement window length in clk40M cycles.
- SETTLE, 16: settle cycles after each trial code change.
- TARGET, 128: expected strobe count per window at lock frequency.

Ports:
- clk40M  in  1  40 MHz reference clock.
- RST  in  1  synchronous, active-high reset.
- startA/startB/startC  in  1  triplicated calibration start; voted.
- modeA/modeB/modeC  in  1  triplicated mode; voted; 1=manual, 0=auto.
- overrideCtrlA/B/C  in  1  triplicated code override; voted; effective only in manual mode.
- overrideVal  in  CODE_W  manual capacitor code.
- enPLL_cfg  in  1  manual PLL enable.
- overrideVc_cfg  in  1  manual Vc override.
- fbEdge  in  1  one-cycle strobe per feedback event, already synchronised to clk40M.
- capCode  out  CODE_W  code driven to the VCO cap bank.
- calCode  out  CODE_W  last completed calibration result.
- busy  out  1  calibration in progress.
- done  out  1  one-cycle pulse on completion.
- calErr  out  1  result pinned at a rail.
- lastCount  out  CNT_W  count from the most recent window.
- pllEnable  out  1  PLL enable.
- overrideVc  out  1  Vc override.

Behaviour:
- Single clock domain; all state is reset synchronously by RST.
- Reset values:
  - capCode = calCode = 1<<(CODE_W-1) (midpoint).
  - busy = done = calErr = 0; lastCount = 0.
  - FSM in IDLE.
- Voting: mode, start and overrideCtrl are each a 2-of-3 majority, registered once.
- Start detection: start_v rising edge, using a registered previous value.
- Combinational outputs:
  - pllEnable = mode_v ? enPLL_cfg : ~busy.
  - overrideVc = mode_v ? overrideVc_cfg : busy.
- FSM states: IDLE, SETTLE, MEASURE, DECIDE, FINISH.
- IDLE:
  - On a start edge with mode_v=0: next cycle busy=1, bit index i=CODE_W-1, trial = 1<<i, go to SETTLE.
  - A start edge while mode_v=1 is ignored.
- SETTLE: hold the trial for SETTLE cycles, then go to MEASURE with the strobe counter cleared.
- MEASURE:
  - Lasts exactly WINDOW cycles.
  - Counter increments on each fbEdge and saturates at all-ones.
- DECIDE (1 cycle):
  - lastCount <= count.
  - If count > TARGET, keep bit i; else clear bit i.
  - If i>0: set bit i-1, decrement i, go to SETTLE. Otherwise go to FINISH.
- FINISH (1 cycle):
  - calCode <= trial; busy <= 0; done <= 1.
  - calErr <= (trial == 0) or (trial == all-ones).
  - Return to IDLE.
- busy is high for exactly CODE_W*(SETTLE+WINDOW+1)+1 cycles.
- capCode selection:
  - mode_v=1 and overrideCtrl_v=1: overrideVal.
  - busy: trial.
  - otherwise: calCode.
- Start edge while busy: ignored.
- mode_v rising while busy: abort to IDLE next cycle. busy=0, no done pulse, calCode and calErr unchanged.
- RST mid-calibration: all outputs return to reset values the following cycle.
- fbEdge during SETTLE/DECIDE/FINISH/IDLE: not counted.

Decomposition:
- Package afc_pkg holds:
  - the FSM state enum;
  - a majority-vote function maj3;
  - the MIDPOINT(CODE_W) constant function.
- One natural sub-module: afc_window_counter. It takes clear, enable and fbEdge, and produces a saturating CNT_W count.
- The SAR FSM, voting and output muxing stay in the top level.

Test Plan:
Defaults apply unless stated. The bench VCO model produces count = 200 - 2*code strobes per window.
- Reset: RST high 3 cycles -> capCode=calCode=6'd32, busy=0, done=0, lastCount=0, pllEnable=1, overrideVc=0.
- Auto calibration: startA/B/C pulse, mode=0 -> trials 32, 48, 40, 36, 34, 35. Expected:
  - busy high exactly 1639 cycles;
  - calCode=35, one done pulse, calErr=0, lastCount=130;
  - overrideVc=1 and pllEnable=0 while busy.
- TMR voting:
  - Only startB toggles -> no calibration.
  - startA+startC -> calibration runs.
  - modeA=1 only, with override asserted -> capCode stays at calCode.
- Manual override: modeA/B/C=1, overrideCtrl A/B/C=1, overrideVal=6'd17 -> capCode=17 next cycle.
  - Clearing overrideCtrl -> capCode returns to calCode.
  - pllEnable follows enPLL_cfg.
- Rail and saturation:
  - Model always gives 4095+ strobes -> calCode=63, calErr=1, lastCount=4095.
  - Model gives 0 strobes -> calCode=0, calErr=1.
- Abort and reset:
  - Mode goes high at cycle 500 of a calibration -> busy drops next cycle, no done, calCode unchanged.
  - RST at cycle 800 of a calibration -> reset values next cycle.
  - A subsequent start completes normally.
